pipe_hazard_ctrl: RTL and testbench
===================================

Name: pipe_hazard_ctrl

Overview:
- Hazard and stall controller that sequences the IF/ID pipeline register and the PC.
- Generates the PC write enable, the IF/ID write enable (if_id_write), the IF/ID flush, and the ID/EX bubble.
- Inputs: decoded ID-stage register fields, EX-stage load info, branch/jump resolution, and a data-memory busy signal.
- Sits between the decode stage and the IF/ID register, next to the forwarding unit.

Parameters:
- LU_STALL_CYC, 1: bubbles inserted per load-use hazard (1..7).
- WAIT_W, 3: width of the internal stall counter.

Ports:
- clk  in  1  pipeline clock
- rst_n  in  1  asynchronous active-low reset
- ce  in  1  clock enable; 0 freezes the controller
- id_rs  in  5  rs field in the ID stage
- id_rt  in  5  rt field in the ID stage
- id_uses_rt  in  1  ID instruction reads rt (R-type, beq, sw)
- ex_mem_read  in  1  EX-stage instruction is a load
- ex_rt  in  5  EX-stage load destination
- branch_taken  in  1  branch resolved taken this cycle
- jump  in  1  jump decoded this cycle
- dmem_busy  in  1  data memory not ready; freeze the whole pipe
- pc_write  out  1  PC update enable
- if_id_write  out  1  IF/ID load enable
- if_id_flush  out  1  IF/ID clear to NOP
- id_ex_bubble  out  1  zero the ID/EX control bits
- pipe_freeze  out  1  hold the EX/MEM and MEM/WB registers
- ctrl_state  out  2  current FSM state, for debug

Behaviour:
- States:
  - RUN=0
  - LU_STALL=1
  - MEM_WAIT=2
  - 3 is unused and returns to RUN.
- Outputs are combinational from the state and the current inputs (Mealy). State, the counter, and pending_flush are registered.
- Reset (rst_n=0, asynchronous):
  - state=RUN, cnt=0, pending_flush=0.
  - pc_write=0, if_id_write=0, if_id_flush=0, id_ex_bubble=0, pipe_freeze=0 while rst_n is low.
- Load-use hazard lu = ex_mem_read & ex_rt!=0 & (ex_rt==id_rs | (id_uses_rt & ex_rt==id_rt)).
- Priority within a cycle: dmem_busy > (branch_taken|jump) > lu.
- RUN:
  - Default outputs: pc_write=1, if_id_write=1, others 0.
  - dmem_busy: pc_write=0, if_id_write=0, pipe_freeze=1. Latch pending_flush=branch_taken|jump. Go to MEM_WAIT.
  - branch_taken|jump: if_id_flush=1, pc_write=1, if_id_write=1. A simultaneous lu is ignored because the ID instruction is squashed. Stay in RUN.
  - lu: pc_write=0, if_id_write=0, id_ex_bubble=1. If LU_STALL_CYC>1, load cnt=LU_STALL_CYC-1 and go to LU_STALL; else stay in RUN.
- LU_STALL:
  - Outputs: pc_write=0, if_id_write=0, id_ex_bubble=1.
  - cnt decrements each enabled cycle; at cnt==1 return to RUN.
  - dmem_busy here preempts: go to MEM_WAIT and keep cnt. On exit, resume LU_STALL if cnt!=0.
- MEM_WAIT:
  - Outputs: pc_write=0, if_id_write=0, pipe_freeze=1, id_ex_bubble=0.
  - branch_taken|jump sets pending_flush.
  - On the first cycle with dmem_busy=0, leave: assert if_id_flush=pending_flush and clear pending_flush.
  - Next state: LU_STALL if cnt!=0, else RUN.
- ce=0:
  - State, cnt and pending_flush hold.
  - Outputs: pc_write=0, if_id_write=0, pipe_freeze=1, if_id_flush=0, id_ex_bubble=0.
- Reset mid-stall or mid-wait aborts immediately to RUN; pending_flush is discarded.
- Loads to register 0 never stall.

Optional Feature:
- Macro: HAZARD_STATS_EN.
- With the macro defined, two extra outputs:
  - stall_cnt[15:0] counts cycles with id_ex_bubble=1.
  - flush_cnt[15:0] counts cycles with if_id_flush=1.
  - Both saturate at 16'hFFFF, reset to 0, and count only when ce=1.
- Without the macro, the ports and logic are absent and core behaviour is identical.

Decomposition:
- Shared package/header holds:
  - state encodings ST_RUN, ST_LU_STALL, ST_MEM_WAIT (2-bit);
  - REG_ZERO=5'd0;
  - opcode constants OP_LW, OP_SW, OP_BEQ, OP_J, used by the decoder that produces id_uses_rt and ex_mem_read.
- One natural sub-module: hazard_detect, the combinational lu compare, reused by the forwarding checker.

Test Plan:
- lw $5 in EX (ex_mem_read=1, ex_rt=5), id_rs=5, LU_STALL_CYC=1 -> exactly one cycle of pc_write=0, if_id_write=0, id_ex_bubble=1, then RUN outputs.
- Same stimulus with LU_STALL_CYC=3 -> three consecutive bubble cycles; ctrl_state 0→1→1→0.
- ex_rt=0 with ex_mem_read=1, id_rs=0 -> no stall.
- branch_taken=1 and lu=1 in the same cycle -> if_id_flush=1, id_ex_bubble=0, pc_write=1.
- dmem_busy high 4 cycles with jump pulsed in cycle 2 -> pipe_freeze=1 for 4 cycles, then a 1-cycle if_id_flush on exit.
- rst_n dropped in LU_STALL cycle 2 -> all outputs 0 immediately; after release ctrl_state=0 with pc_write=1.

Source files
------------

// File: rtl/pipe_hazard_ctrl_pkg.sv
// pipe_hazard_ctrl_pkg
//   Shared definitions for the pipeline hazard controller and its helpers:
//   controller state encodings, the hard-wired zero register number, and the
//   opcode constants used by the decoder that produces id_uses_rt and
//   ex_mem_read.
package pipe_hazard_ctrl_pkg;

   typedef enum logic [1:0] {
      ST_RUN      = 2'd0,
      ST_LU_STALL = 2'd1,
      ST_MEM_WAIT = 2'd2,
      ST_UNUSED   = 2'd3
   } state_t;

   localparam logic [4:0] REG_ZERO = 5'd0;

   localparam logic [5:0] OP_LW  = 6'h23;
   localparam logic [5:0] OP_SW  = 6'h2b;
   localparam logic [5:0] OP_BEQ = 6'h04;
   localparam logic [5:0] OP_J   = 6'h02;

   // Any control transfer squashes the instruction sitting in IF/ID.
   function automatic logic redirect(input logic branch_taken, input logic jump);
      return branch_taken | jump;
   endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_hazard_detect.sv
// pipe_hazard_ctrl_hazard_detect
//   Combinational load-use compare: flags when the load in EX writes a
//   register that the instruction in ID reads. Loads to register 0 never
//   hazard. Also used by the forwarding checker.
// Ports:
//   id_rs, id_rt   ID-stage source register fields
//   id_uses_rt     ID instruction actually reads rt
//   ex_mem_read    EX-stage instruction is a load
//   ex_rt          EX-stage load destination
//   lu             load-use hazard present
module pipe_hazard_ctrl_hazard_detect
   import pipe_hazard_ctrl_pkg::*;
(
   input  logic [4:0] id_rs,
   input  logic [4:0] id_rt,
   input  logic       id_uses_rt,
   input  logic       ex_mem_read,
   input  logic [4:0] ex_rt,
   output logic       lu
);

   assign lu = ex_mem_read && (ex_rt != REG_ZERO) &&
               ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl
//   Hazard and stall controller for the IF/ID register and the PC. Inserts
//   load-use bubbles, flushes IF/ID on taken branches and jumps, and freezes
//   the pipe while data memory is busy (remembering any redirect seen during
//   the freeze so IF/ID is flushed on the way out).
// Optional build macro: HAZARD_STATS_EN adds stall_cnt / flush_cnt.
// Ports:
//   clk, rst_n      pipeline clock, asynchronous active-low reset
//   ce              clock enable; low freezes the controller
//   id_rs, id_rt, id_uses_rt    ID-stage register usage
//   ex_mem_read, ex_rt          EX-stage load info
//   branch_taken, jump          control-transfer resolution
//   dmem_busy                   data memory not ready
//   pc_write, if_id_write, if_id_flush, id_ex_bubble, pipe_freeze  controls
//   ctrl_state                  current state (debug)
//   stall_cnt, flush_cnt        saturating event counters (HAZARD_STATS_EN)
//
// state       | meaning
// ST_RUN      | normal flow; reacts to busy, redirect, load-use
// ST_LU_STALL | extra load-use bubbles, cnt = bubbles still owed
// ST_MEM_WAIT | memory busy, whole pipe held; cnt keeps owed bubbles
// ST_UNUSED   | illegal, returns to ST_RUN
module pipe_hazard_ctrl
   import pipe_hazard_ctrl_pkg::*;
#(
   parameter int LU_STALL_CYC = 1,
   parameter int WAIT_W       = 3
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       ce,
   input  logic [4:0] id_rs,
   input  logic [4:0] id_rt,
   input  logic       id_uses_rt,
   input  logic       ex_mem_read,
   input  logic [4:0] ex_rt,
   input  logic       branch_taken,
   input  logic       jump,
   input  logic       dmem_busy,
   output logic       pc_write,
   output logic       if_id_write,
   output logic       if_id_flush,
   output logic       id_ex_bubble,
   output logic       pipe_freeze,
   output logic [1:0] ctrl_state
`ifdef HAZARD_STATS_EN
   ,
   output logic [15:0] stall_cnt,
   output logic [15:0] flush_cnt
`endif
);

   localparam logic [WAIT_W-1:0] CNT_LOAD = WAIT_W'(LU_STALL_CYC - 1);
   localparam logic [WAIT_W-1:0] CNT_ONE  = WAIT_W'(1);

   state_t            state_q, state_d;
   logic [WAIT_W-1:0] cnt_q, cnt_d;
   logic              pend_q, pend_d;
   logic              lu, redir;
   logic              pc_w, ifid_w, flush_w, bubble_w, freeze_w;

   pipe_hazard_ctrl_hazard_detect u_hazard_detect (
      .id_rs       (id_rs),
      .id_rt       (id_rt),
      .id_uses_rt  (id_uses_rt),
      .ex_mem_read (ex_mem_read),
      .ex_rt       (ex_rt),
      .lu          (lu)
   );

   assign redir = redirect(branch_taken, jump);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_RUN;
         cnt_q   <= '0;
         pend_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         pend_q  <= pend_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      pend_d   = pend_q;
      pc_w     = 1'b0;
      ifid_w   = 1'b0;
      flush_w  = 1'b0;
      bubble_w = 1'b0;
      freeze_w = 1'b0;
      if (!ce) begin
         freeze_w = 1'b1;
      end else begin
         case (state_q)
            ST_RUN: begin
               if (dmem_busy) begin
                  freeze_w = 1'b1;
                  pend_d   = redir;
                  state_d  = ST_MEM_WAIT;
               end else if (redir) begin
                  // ID instruction is squashed, so any load-use on it is moot.
                  pc_w    = 1'b1;
                  ifid_w  = 1'b1;
                  flush_w = 1'b1;
               end else if (lu) begin
                  bubble_w = 1'b1;
                  if (LU_STALL_CYC > 1) begin
                     cnt_d   = CNT_LOAD;
                     state_d = ST_LU_STALL;
                  end
               end else begin
                  pc_w   = 1'b1;
                  ifid_w = 1'b1;
               end
            end
            ST_LU_STALL: begin
               if (dmem_busy) begin
                  // Owed bubbles are kept in cnt and resumed after the wait.
                  freeze_w = 1'b1;
                  pend_d   = redir;
                  state_d  = ST_MEM_WAIT;
               end else begin
                  bubble_w = 1'b1;
                  if (cnt_q > CNT_ONE) begin
                     cnt_d = cnt_q - CNT_ONE;
                  end else begin
                     cnt_d   = '0;
                     state_d = ST_RUN;
                  end
               end
            end
            ST_MEM_WAIT: begin
               if (dmem_busy) begin
                  freeze_w = 1'b1;
                  pend_d   = pend_q | redir;
               end else begin
                  flush_w = pend_q;
                  pend_d  = 1'b0;
                  state_d = (cnt_q != '0) ? ST_LU_STALL : ST_RUN;
               end
            end
            default: begin
               cnt_d   = '0;
               pend_d  = 1'b0;
               state_d = ST_RUN;
            end
         endcase
      end
   end

   // Outputs are forced low for as long as reset is asserted.
   assign pc_write     = rst_n & pc_w;
   assign if_id_write  = rst_n & ifid_w;
   assign if_id_flush  = rst_n & flush_w;
   assign id_ex_bubble = rst_n & bubble_w;
   assign pipe_freeze  = rst_n & freeze_w;
   assign ctrl_state   = state_q;

`ifdef HAZARD_STATS_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stall_cnt <= '0;
         flush_cnt <= '0;
      end else if (ce) begin
         if (id_ex_bubble && (stall_cnt != 16'hFFFF)) stall_cnt <= stall_cnt + 16'd1;
         if (if_id_flush && (flush_cnt != 16'hFFFF)) flush_cnt <= flush_cnt + 16'd1;
      end
   end
`else
   // Statistics counters are not built.
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb_pipe_hazard_ctrl
//   Two controllers (1 and 3 load-use bubbles) share one stimulus stream.
//   A behavioural model predicts each cycle's outputs into per-instance
//   queues; a monitor on the falling edge pops and compares.
module tb_pipe_hazard_ctrl;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       ce = 1'b1;
   logic [4:0] id_rs = '0, id_rt = '0, ex_rt = '0;
   logic       id_uses_rt = 1'b0, ex_mem_read = 1'b0;
   logic       branch_taken = 1'b0, jump = 1'b0, dmem_busy = 1'b0;

   logic       a_pc, a_ifw, a_fl, a_bb, a_fz;
   logic [1:0] a_st;
   logic       b_pc, b_ifw, b_fl, b_bb, b_fz;
   logic [1:0] b_st;

   int checks = 0;
   int errors = 0;

   logic [6:0] q0[$];
   logic [6:0] q1[$];

   // model state: bubbles still owed, waiting on memory, flush pending
   int bubbles   [2] = '{1, 3};
   int owed      [2] = '{0, 0};
   bit waiting   [2] = '{0, 0};
   bit pending   [2] = '{0, 0};

   always #5 clk = ~clk;

   pipe_hazard_ctrl #(.LU_STALL_CYC(1), .WAIT_W(3)) u_p1 (
      .clk(clk), .rst_n(rst_n), .ce(ce), .id_rs(id_rs), .id_rt(id_rt),
      .id_uses_rt(id_uses_rt), .ex_mem_read(ex_mem_read), .ex_rt(ex_rt),
      .branch_taken(branch_taken), .jump(jump), .dmem_busy(dmem_busy),
      .pc_write(a_pc), .if_id_write(a_ifw), .if_id_flush(a_fl),
      .id_ex_bubble(a_bb), .pipe_freeze(a_fz), .ctrl_state(a_st)
   );

   pipe_hazard_ctrl #(.LU_STALL_CYC(3), .WAIT_W(3)) u_p3 (
      .clk(clk), .rst_n(rst_n), .ce(ce), .id_rs(id_rs), .id_rt(id_rt),
      .id_uses_rt(id_uses_rt), .ex_mem_read(ex_mem_read), .ex_rt(ex_rt),
      .branch_taken(branch_taken), .jump(jump), .dmem_busy(dmem_busy),
      .pc_write(b_pc), .if_id_write(b_ifw), .if_id_flush(b_fl),
      .id_ex_bubble(b_bb), .pipe_freeze(b_fz), .ctrl_state(b_st)
   );

   // Expected {ctrl_state, pc_write, if_id_write, if_id_flush, id_ex_bubble,
   // pipe_freeze} for this cycle; advances the model to the next cycle.
   task automatic model(input int k, output logic [6:0] e);
      bit lu, redir, pc, ifw, fl, bb, fz;
      logic [1:0] st;
      lu = ex_mem_read && (ex_rt != 0) &&
           ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));
      redir = branch_taken || jump;
      st = waiting[k] ? 2'd2 : ((owed[k] > 0) ? 2'd1 : 2'd0);
      pc = 0; ifw = 0; fl = 0; bb = 0; fz = 0;
      if (!rst_n) begin
         owed[k] = 0; waiting[k] = 0; pending[k] = 0; st = 2'd0;
      end else if (!ce) begin
         fz = 1;
      end else if (waiting[k]) begin
         if (dmem_busy) begin
            fz = 1;
            pending[k] = pending[k] || redir;
         end else begin
            fl = pending[k];
            pending[k] = 0;
            waiting[k] = 0;
         end
      end else if (dmem_busy) begin
         fz = 1;
         pending[k] = redir;
         waiting[k] = 1;
      end else if (owed[k] > 0) begin
         bb = 1;
         owed[k] = owed[k] - 1;
      end else if (redir) begin
         pc = 1; ifw = 1; fl = 1;
      end else if (lu) begin
         bb = 1;
         owed[k] = bubbles[k] - 1;
      end else begin
         pc = 1; ifw = 1;
      end
      e = {st, pc, ifw, fl, bb, fz};
   endtask

   task automatic cyc(input bit r, input bit c, input logic [4:0] rs,
                      input logic [4:0] rt, input bit ur, input bit mr,
                      input logic [4:0] ert, input bit br, input bit jp,
                      input bit bz);
      logic [6:0] e;
      @(posedge clk);
      #1;
      rst_n = r; ce = c; id_rs = rs; id_rt = rt; id_uses_rt = ur;
      ex_mem_read = mr; ex_rt = ert; branch_taken = br; jump = jp;
      dmem_busy = bz;
      model(0, e); q0.push_back(e);
      model(1, e); q1.push_back(e);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cyc(1, 1, 0, 0, 0, 0, 0, 0, 0, 0);
   endtask

   always @(negedge clk) begin
      logic [6:0] e, a;
      if (q0.size() > 0) begin
         e = q0.pop_front();
         a = {a_st, a_pc, a_ifw, a_fl, a_bb, a_fz};
         checks++;
         if (a !== e) begin
            errors++;
            $display("FAIL out_stall1 t=%0t got %b expected %b (st,pc,ifw,fl,bb,fz)", $time, a, e);
         end
      end
      if (q1.size() > 0) begin
         e = q1.pop_front();
         a = {b_st, b_pc, b_ifw, b_fl, b_bb, b_fz};
         checks++;
         if (a !== e) begin
            errors++;
            $display("FAIL out_stall3 t=%0t got %b expected %b (st,pc,ifw,fl,bb,fz)", $time, a, e);
         end
      end
   end

   initial begin
      cyc(0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
      cyc(0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
      idle(2);
      // load-use on rs
      cyc(1, 1, 5, 0, 0, 1, 5, 0, 0, 0);
      idle(4);
      // load to register 0
      cyc(1, 1, 0, 0, 0, 1, 0, 0, 0, 0);
      idle(1);
      // branch together with load-use
      cyc(1, 1, 5, 0, 0, 1, 5, 1, 0, 0);
      idle(1);
      // memory busy for 4 cycles, jump in the second
      cyc(1, 1, 0, 0, 0, 0, 0, 0, 0, 1);
      cyc(1, 1, 0, 0, 0, 0, 0, 0, 1, 1);
      cyc(1, 1, 0, 0, 0, 0, 0, 0, 0, 1);
      cyc(1, 1, 0, 0, 0, 0, 0, 0, 0, 1);
      idle(3);
      // reset in the middle of a stall
      cyc(1, 1, 5, 0, 0, 1, 5, 0, 0, 0);
      idle(1);
      cyc(0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
      idle(2);
      // clock-enable low and memory busy during a stall
      cyc(1, 1, 5, 0, 0, 1, 5, 0, 0, 0);
      cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      cyc(1, 1, 0, 0, 0, 0, 0, 0, 0, 1);
      cyc(1, 1, 0, 0, 0, 0, 0, 0, 0, 1);
      idle(4);
      // rt match only counts when rt is read
      cyc(1, 1, 1, 5, 1, 1, 5, 0, 0, 0);
      idle(3);
      cyc(1, 1, 1, 5, 0, 1, 5, 0, 0, 0);
      idle(1);
      for (int i = 0; i < 2000; i++) begin
         cyc(($urandom_range(0, 63) != 0), ($urandom_range(0, 7) != 0),
             5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
             ($urandom_range(0, 1) == 1), ($urandom_range(0, 1) == 1),
             5'($urandom_range(0, 3)), ($urandom_range(0, 9) == 0),
             ($urandom_range(0, 11) == 0), ($urandom_range(0, 4) == 0));
      end
      idle(1);
      repeat (4) @(negedge clk);
      if ((q0.size() != 0) || (q1.size() != 0)) begin
         errors++;
         $display("FAIL drain got %0d/%0d pending expected 0/0", q0.size(), q1.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
